uart_tx_frame: RTL and testbench

- Serialises one byte as an asynchronous UART frame on `TX`.
- Sits directly downstream of the rising-edge detector: that detector's single-cycle `out` pulse drives `trmt` here.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); idle line is high.
- Reports completion with a sticky `tx_done` flag and a `busy` level.

---
 rtl/uart_tx_frame.sv | 88 ++++++++
 tb/tb_uart_tx_frame.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, optional even parity, 1 stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_tx_frame #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       busy,
  output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
  localparam int SR_W = 10;
  localparam logic [3:0] FRAME_BITS = 4'd11;
`else
  localparam int SR_W = 9;
  localparam logic [3:0] FRAME_BITS = 4'd10;
`endif

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BIT  = FRAME_BITS - 4'd1;

  typedef enum logic {IDLE, XMIT} state_t;

  state_t            r_state;
  logic [SR_W-1:0]   r_shift;
  logic [11:0]       r_baud;
  logic [3:0]        r_bit;
  logic              r_busy;
  logic              r_done;
  logic [SR_W-1:0]   w_load;
  logic              w_shift;

`ifdef UART_TX_PARITY_EN
  assign w_load = {1'b1, ^tx_data, tx_data, 1'b0};
`else
  assign w_load = {tx_data, 1'b0};
`endif

  assign w_shift = (r_state == XMIT) && (r_baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (trmt) begin
            r_shift <= w_load;
            r_baud  <= '0;
            r_bit   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= XMIT;
          end
        end
        XMIT: begin
          if (w_shift) begin
            r_baud  <= '0;
            // Ones shifted in supply the stop level and keep the line high once idle.
            r_shift <= {1'b1, r_shift[SR_W-1:1]};
            r_bit   <= r_bit + 4'd1;
            if (r_bit == LAST_BIT) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 12'd1;
          end
        end
      endcase
    end
  end

  assign TX      = r_shift[0];
  assign busy    = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame with BAUD_DIV=16 and an upstream rising-edge detector.
module tb_uart_tx_frame;

  localparam int BD = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic       trmt;
  logic       trmt_m;
  logic [7:0] tx_data;
  logic       TX;
  logic       busy;
  logic       tx_done;
  logic       next_byte;
  logic       next_q;

  int checks = 0;
  int errors = 0;

  uart_tx_frame #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .busy    (busy),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream rising-edge detector feeding trmt.
  initial next_q = 1'b0;
  always @(posedge clk) next_q <= next_byte;
  assign trmt = trmt_m | (next_byte & ~next_q);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for each bit slot of a frame carrying d.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    if (FB == 11) b[9] = ^d;
    return b;
  endfunction

  // Starts a frame (via trmt or the edge detector), follows it to completion and checks it.
  task automatic send_frame(input logic [7:0] d, input int inject_at, input bit use_det);
    logic [10:0] eb;
    int bad;
    eb = frame_bits(d);
    bad = 0;
    tx_data = d;
    if (use_det) next_byte = 1'b1;
    else trmt_m = 1'b1;
    tick();
    trmt_m = 1'b0;
    $display("frame start data=%02h inject=%0d det=%0d", d, inject_at, use_det);
    chk("start_tx", 32'(TX), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(tx_done), 32'd0);
    for (int c = 1; c <= FB * BD; c++) begin
      tick();
      tx_data = 8'($urandom);
      if (inject_at != 0 && c == inject_at) begin
        trmt_m = 1'b1;
        tx_data = 8'hFF;
      end
      if (c < FB * BD) begin
        if (TX !== eb[c / BD] || busy !== 1'b1 || tx_done !== 1'b0) bad++;
        if (c % BD == BD / 2) chk($sformatf("bit%0d", c / BD), 32'(TX), 32'(eb[c / BD]));
      end else begin
        chk("done_rise", 32'(tx_done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_tx", 32'(TX), 32'd1);
      end
    end
    trmt_m = 1'b0;
    chk("frame_hold", 32'(bad), 32'd0);
    $display("frame end data=%02h hold_errors=%0d", d, bad);
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (TX !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    trmt_m = 1'b0;
    tx_data = 8'h00;
    next_byte = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_check("idle_after_reset", 4);

    // Basic frame.
    send_frame(8'hA5, 0, 1'b0);
    idle_check("idle_a5", 3);

    // Second request during XMIT must be ignored.
    send_frame(8'h3C, 50, 1'b0);
    idle_check("no_second_frame", 40);
    chk("done_sticky", 32'(tx_done), 32'd1);

    // Back-to-back: new request in the first IDLE cycle after tx_done.
    send_frame(8'h00, 0, 1'b0);
    send_frame(8'hFF, 0, 1'b0);
    idle_check("idle_b2b", 3);

    // Reset in the middle of a frame.
    tx_data = 8'h55;
    trmt_m = 1'b1;
    tick();
    trmt_m = 1'b0;
    repeat (70) tick();
    rst_n = 1'b0;
    #1;
    $display("reset mid-frame applied");
    chk("midrst_tx", 32'(TX), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(tx_done), 32'd0);
    tick();
    rst_n = 1'b1;
    idle_check("idle_after_midrst", 3);
    chk("midrst_done_held", 32'(tx_done), 32'd0);
    send_frame(8'h55, 0, 1'b0);

`ifdef UART_TX_PARITY_EN
    send_frame(8'h07, 0, 1'b0);
    send_frame(8'h03, 0, 1'b0);
`endif

    // Edge-detector integration: one frame per rising edge of next_byte.
    idle_check("idle_pre_det", 2);
    send_frame(8'h81, 0, 1'b1);
    idle_check("det_held_high", 40);
    next_byte = 1'b0;
    tick();
    send_frame(8'h81, 0, 1'b1);
    next_byte = 1'b0;
    idle_check("idle_post_det", 3);

    // Randomized bytes and gaps.
    for (int k = 0; k < 6; k++) begin
      int gap;
      gap = $urandom_range(0, 4);
      send_frame(8'($urandom), 0, 1'b0);
      if (gap != 0) idle_check("rand_gap", gap);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
